octal_spi_cmd_decoder: RTL



---
 rtl/octal_spi_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 79 +++++++
 rtl/octal_spi_cmd_decoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/octal_spi_pkg.sv
// Shared definitions for the octal SPI command decoder: opcodes, FSM states
// and the layout of one write beat as stored in the FIFO.
package octal_spi_pkg;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;

  // Frames always carry a 16-bit address; the decoder truncates it.
  localparam int FRAME_ADDR_W = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OP,
    ST_AH,
    ST_AL,
    ST_LEN,
    ST_WDATA,
    ST_FVAL,
    ST_FILL,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic [FRAME_ADDR_W-1:0] addr;
    logic [7:0]              data;
  } fifo_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head. A push into an empty FIFO is
// visible on head_data at the very edge that writes it. Capacity is DEPTH
// entries (DEPTH must be a power of two, >= 2). A push while full is
// accepted only if the head is popped in the same cycle; otherwise it is
// dropped and flagged on 'drop'.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] head_reg;

  logic             do_push;
  logic             do_pop;
  logic [PTR_W-1:0] rd_ptr_inc;

  assign empty      = (count_reg == '0);
  assign full       = (count_reg == CNT_FULL);
  assign do_pop     = pop && !empty;
  assign do_push    = push && (!full || do_pop);
  assign drop       = push && !do_push;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign head_data  = head_reg;

  // Storage array; no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Registered head: load the incoming word when it becomes the head,
  // otherwise advance to the next stored word on a pop; hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_reg <= '0;
    end else if (do_push && (empty || (do_pop && count_reg == CNT_ONE))) begin
      head_reg <= push_data;
    end else if (do_pop && count_reg > CNT_ONE) begin
      head_reg <= mem[rd_ptr_inc];
    end
  end

endmodule

// File: rtl/octal_spi_cmd_decoder.sv
// Octal SPI command decoder: parses one WRITE/FILL/NOP command per cs frame
// from a byte-wide MOSI stream and emits write beats through a small FIFO.
// Optional statistics outputs (frame_cnt, err_cnt) are built when the macro
// OCTAL_SPI_DECODER_STATS_EN is defined.
module octal_spi_cmd_decoder
  import octal_spi_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic [7:0]        mosi,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              err
`ifdef OCTAL_SPI_DECODER_STATS_EN
  ,
  output logic [7:0]        frame_cnt,
  output logic [7:0]        err_cnt
`endif
);

  logic              cs_q;
  logic [7:0]        mosi_q;
  state_t            state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        addr_hi_reg;
  logic [7:0]        count_reg;
  logic [7:0]        value_reg;
  logic              is_fill_reg;
  logic              err_reg;

  logic              push;
  fifo_entry_t       push_entry;
  fifo_entry_t       head_entry;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_drop;

  logic              cs_fall_now;
  logic              in_header;
  logic              truncated;
  logic              bad_op;
  logic              fill_collide;
  logic              err_event;

  // Register the raw SPI inputs once; cs idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_q   <= 1'b1;
      mosi_q <= '0;
    end else begin
      cs_q   <= cs;
      mosi_q <= mosi;
    end
  end

  // cs_q falls at the coming edge, so the state enters OP exactly when the
  // opcode byte lands in mosi_q.
  assign cs_fall_now  = !cs && cs_q;
  assign in_header    = (state_reg == ST_OP)  || (state_reg == ST_AH)    ||
                        (state_reg == ST_AL)  || (state_reg == ST_LEN)   ||
                        (state_reg == ST_WDATA) || (state_reg == ST_FVAL);
  assign truncated    = in_header && cs_q;
  assign bad_op       = (state_reg == ST_OP) && !cs_q &&
                        (mosi_q != OP_NOP) && (mosi_q != OP_WRITE) && (mosi_q != OP_FILL);
  assign fill_collide = (state_reg == ST_FILL) && cs_fall_now;
  assign err_event    = truncated || bad_op || fill_collide || fifo_drop;

  // Beat generation: one per accepted data byte, or one per free FIFO slot in FILL.
  always_comb begin
    push            = 1'b0;
    push_entry      = '0;
    push_entry.addr = FRAME_ADDR_W'(addr_reg);
    push_entry.data = mosi_q;
    if (state_reg == ST_WDATA && !cs_q) begin
      push = 1'b1;
    end else if (state_reg == ST_FILL && !fifo_full) begin
      push            = 1'b1;
      push_entry.data = value_reg;
    end
  end

  // Frame parser FSM with its datapath registers and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      addr_reg    <= '0;
      addr_hi_reg <= '0;
      count_reg   <= '0;
      value_reg   <= '0;
      is_fill_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      if (err_event) err_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (cs_fall_now) state_reg <= ST_OP;
        end
        ST_OP: begin
          if (cs_q) begin
            state_reg <= ST_IDLE;
          end else begin
            is_fill_reg <= (mosi_q == OP_FILL);
            if (mosi_q == OP_WRITE || mosi_q == OP_FILL) state_reg <= ST_AH;
            else                                         state_reg <= ST_SKIP;
          end
        end
        ST_AH: begin
          if (cs_q) begin
            state_reg <= ST_IDLE;
          end else begin
            addr_hi_reg <= mosi_q;
            state_reg   <= ST_AL;
          end
        end
        ST_AL: begin
          if (cs_q) begin
            state_reg <= ST_IDLE;
          end else begin
            addr_reg  <= ADDR_W'({addr_hi_reg, mosi_q});
            state_reg <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (cs_q) begin
            state_reg <= ST_IDLE;
          end else begin
            count_reg <= mosi_q;
            state_reg <= is_fill_reg ? ST_FVAL : ST_WDATA;
          end
        end
        ST_WDATA: begin
          if (cs_q) begin
            state_reg <= ST_IDLE;
          end else begin
            // Address advances even for a dropped byte so later beats stay aligned.
            addr_reg <= addr_reg + 1'b1;
            if (count_reg == 8'd0) state_reg <= ST_SKIP;
            else                   count_reg <= count_reg - 1'b1;
          end
        end
        ST_FVAL: begin
          if (cs_q) begin
            state_reg <= ST_IDLE;
          end else begin
            value_reg <= mosi_q;
            state_reg <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (!fifo_full) begin
            addr_reg <= addr_reg + 1'b1;
            if (count_reg == 8'd0) state_reg <= cs_q ? ST_IDLE : ST_SKIP;
            else                   count_reg <= count_reg - 1'b1;
          end
        end
        ST_SKIP: begin
          if (cs_q) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign pop = wr_valid && wr_ready;

  sync_fifo #(
    .WIDTH($bits(fifo_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head_data(head_entry),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .drop     (fifo_drop)
  );

  assign wr_valid = !fifo_empty;
  assign wr_addr  = head_entry.addr[ADDR_W-1:0];
  assign wr_data  = head_entry.data;
  assign busy     = (state_reg != ST_IDLE) || !fifo_empty;
  assign err      = err_reg;

`ifdef OCTAL_SPI_DECODER_STATS_EN
  logic       frame_ok_reg;
  logic [7:0] frame_cnt_reg;
  logic [7:0] err_cnt_reg;
  logic       frame_done;

  // A frame counts when its valid command finishes and no error hit it.
  assign frame_done = frame_ok_reg && !err_event &&
                      (((state_reg == ST_SKIP) && cs_q) ||
                       ((state_reg == ST_FILL) && !fifo_full && (count_reg == 8'd0) && cs_q));

  // Saturating frame and error-event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_ok_reg  <= 1'b0;
      frame_cnt_reg <= '0;
      err_cnt_reg   <= '0;
    end else begin
      if (state_reg == ST_OP && !cs_q && !bad_op) frame_ok_reg <= 1'b1;
      else if (err_event || frame_done)           frame_ok_reg <= 1'b0;
      if (frame_done && frame_cnt_reg != 8'hFF) frame_cnt_reg <= frame_cnt_reg + 1'b1;
      if (err_event && err_cnt_reg != 8'hFF)    err_cnt_reg   <= err_cnt_reg + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign err_cnt   = err_cnt_reg;
`endif

endmodule
